// File: rtl/onehot_seq_decoder.sv
// One-hot sequence decoder: direct decode, up/down scanning with wrap flag,
// and a fixed-length one-hot pulse generator. All outputs are registered.
module onehot_seq_decoder #(
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      din,
  input  logic                  start,
  output logic [2**SEL_W-1:0]   dout,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap,
  output logic                  busy
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    M_DECODE = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_PULSE  = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE,
    PULSE
  } state_t;

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   idx_n;
  logic               valid_n, busy_n, wrap_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [OUT_W-1:0]   dout_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      dout    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx     <= idx_n;
      valid   <= valid_n;
      busy    <= busy_n;
      wrap    <= wrap_n;
      dout    <= dout_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx;
    valid_n = valid;
    busy_n  = busy;
    wrap_n  = 1'b0;

    if (en) begin
      case (mode_t'(mode))
        M_DECODE: begin
          idx_n   = din;
          valid_n = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
        M_UP: begin
          // A scan only steps (and may wrap) once a valid index exists.
          idx_n   = valid ? idx + SEL_W'(1) : din;
          wrap_n  = valid && (idx == '1);
          valid_n = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
        M_DOWN: begin
          idx_n   = valid ? idx - SEL_W'(1) : din;
          wrap_n  = valid && (idx == '0);
          valid_n = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
        M_PULSE: begin
          case (state_q)
            IDLE: begin
              if (start) begin
                idx_n   = din;
                valid_n = 1'b1;
                busy_n  = 1'b1;
                cnt_n   = CNT_W'(PULSE_LEN - 1);
                state_n = PULSE;
              end else begin
                valid_n = 1'b0;
              end
            end
            PULSE: begin
              if (cnt_q != '0) begin
                cnt_n = cnt_q - CNT_W'(1);
              end else begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
              end
            end
            default: state_n = IDLE;
          endcase
        end
        default: ;
      endcase
    end

    dout_n = '0;
    if (valid_n) dout_n[idx_n] = 1'b1;
  end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Scoreboard bench for onehot_seq_decoder: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model.
module tb_onehot_seq_decoder;

  localparam int SEL_W     = 2;
  localparam int PULSE_LEN = 4;
  localparam int OUT_W     = 2**SEL_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [SEL_W-1:0]   din = '0;
  logic               start = 1'b0;
  logic [OUT_W-1:0]   dout;
  logic [SEL_W-1:0]   idx;
  logic               valid, wrap, busy;

  onehot_seq_decoder #(.SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .start(start),
    .dout(dout), .idx(idx), .valid(valid), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             wrap;
    logic             busy;
    string            tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: index as an integer, pulse tracked as cycles already shown.
  int m_idx = 0, m_valid = 0, m_busy = 0, m_wrap = 0, m_shown = 0;

  task automatic model_step(input bit r, input bit e, input int md, input int d, input bit s);
    if (r) begin
      m_idx = 0; m_valid = 0; m_busy = 0; m_wrap = 0; m_shown = 0;
    end else if (!e) begin
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (md)
        0: begin m_idx = d; m_valid = 1; m_busy = 0; m_shown = 0; end
        1: begin
          if (m_valid) begin
            if (m_idx == OUT_W-1) m_wrap = 1;
            m_idx = (m_idx + 1) % OUT_W;
          end else m_idx = d;
          m_valid = 1; m_busy = 0; m_shown = 0;
        end
        2: begin
          if (m_valid) begin
            if (m_idx == 0) m_wrap = 1;
            m_idx = (m_idx + OUT_W - 1) % OUT_W;
          end else m_idx = d;
          m_valid = 1; m_busy = 0; m_shown = 0;
        end
        default: begin
          if (!m_busy) begin
            if (s) begin m_idx = d; m_valid = 1; m_busy = 1; m_shown = 1; end
            else m_valid = 0;
          end else if (m_shown >= PULSE_LEN) begin
            m_valid = 0; m_busy = 0; m_shown = 0;
          end else begin
            m_shown++;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, input bit e, input int md, input int d, input bit s,
                      input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = 2'(md); din = SEL_W'(d); start = s;
    model_step(r, e, md, d, s);
    x.dout  = m_valid ? OUT_W'(1) << m_idx : '0;
    x.idx   = SEL_W'(m_idx);
    x.valid = 1'(m_valid);
    x.wrap  = 1'(m_wrap);
    x.busy  = 1'(m_busy);
    x.tag   = tag;
    q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle, so compare one entry per edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (dout !== x.dout || idx !== x.idx || valid !== x.valid ||
            wrap !== x.wrap || busy !== x.busy) begin
          failures++;
          $display("FAIL %s t=%0t got dout=%b idx=%0d valid=%b wrap=%b busy=%b want dout=%b idx=%0d valid=%b wrap=%b busy=%b",
                   x.tag, $time, dout, idx, valid, wrap, busy,
                   x.dout, x.idx, x.valid, x.wrap, x.busy);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cur_mode;
    bit r, e, s;
    // reset held two cycles
    step(1, 0, 0, 0, 0, "reset1");
    step(1, 0, 0, 0, 0, "reset2");
    // decode then hold
    step(0, 1, 0, 2, 0, "decode2");
    step(0, 0, 0, 3, 0, "hold_en0");
    step(0, 0, 0, 1, 0, "hold_en0b");
    // scan up from invalid, seeded at 2, wraps 3->0
    step(1, 0, 0, 0, 0, "rst_scan");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2, 0, "scan_up");
    // scan down seeded at 0
    step(1, 0, 0, 0, 0, "rst_down");
    for (int i = 0; i < 4; i++) step(0, 1, 2, 0, 0, "scan_down");
    // en=0 during scan drops wrap and holds idx
    step(0, 0, 2, 0, 0, "down_hold");
    // pulse: start one cycle, retrigger attempt while busy
    step(0, 1, 3, 1, 0, "pulse_idle");
    step(0, 1, 3, 1, 1, "pulse_start");
    step(0, 1, 3, 3, 1, "pulse_retrig");
    for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0, "pulse_run");
    // pulse stretched by two disabled cycles
    step(0, 1, 3, 2, 1, "pulse2_start");
    step(0, 1, 3, 0, 0, "pulse2_run");
    step(0, 0, 3, 0, 0, "pulse2_stall");
    step(0, 0, 3, 0, 0, "pulse2_stall");
    for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 0, "pulse2_run");
    // reset in the second pulse cycle
    step(0, 1, 3, 3, 1, "pulse3_start");
    step(1, 1, 3, 3, 1, "pulse3_rst");
    step(0, 1, 3, 0, 0, "pulse3_after");
    // leaving pulse mode mid-pulse
    step(0, 1, 3, 1, 1, "pulse4_start");
    step(0, 1, 1, 0, 0, "pulse4_to_up");
    step(0, 1, 3, 2, 1, "pulse4_restart");
    for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0, "pulse4_run");

    // randomized traffic
    cur_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_mode = $urandom_range(0, 3);
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 30);
      step(r, e, cur_mode, $urandom_range(0, OUT_W-1), s, "random");
    end

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_seq_decoder.md
ONEHOT_SEQ_DECODER -- requirements
Module: onehot_seq_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select/index width, legal range 1..6.
REQ-002 SHALL have parameter PULSE_LEN, default 4: pulse-mode output duration in enabled cycles, legal range 1..256.
REQ-003 SHALL derive local constant OUT_W = 2**SEL_W (not overridable).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  clock enable; 0 = hold all state.
REQ-007 SHALL have port mode  input  2  00 decode, 01 scan-up, 10 scan-down, 11 pulse.
REQ-008 SHALL have port din  input  SEL_W  select value / scan seed.
REQ-009 SHALL have port start  input  1  pulse-mode trigger; ignored in other modes.
REQ-010 SHALL have port dout  output  OUT_W  registered one-hot output.
REQ-011 SHALL have port idx  output  SEL_W  registered current index.
REQ-012 SHALL have port valid  output  1  dout carries a one-hot code.
REQ-013 SHALL have port wrap  output  1  one-cycle flag on scan wrap-around.
REQ-014 SHALL have port busy  output  1  pulse in progress.

Function
REQ-015 SHALL register all outputs; 1-cycle latency from sampling edge to output.
REQ-016 SHALL hold dout = one-hot(idx) when valid=1 and dout = 0 when valid=0.
REQ-017 SHALL, with en=0, hold idx, valid, dout, busy and the pulse counter, and drive wrap=0.
REQ-018 SHALL, in mode 00 with en=1, load idx<=din and set valid<=1.
REQ-019 SHALL, in mode 01 with en=1, seed idx<=din if valid=0, else advance idx<=idx+1 mod OUT_W; valid<=1.
REQ-020 SHALL, in mode 10 with en=1, seed idx<=din if valid=0, else step idx<=idx-1 mod OUT_W; valid<=1.
REQ-021 SHALL assert wrap for exactly one cycle when a scan step moves OUT_W-1->0 (mode 01) or 0->OUT_W-1 (mode 10); never on seed.
REQ-022 SHALL implement pulse mode as a two-state FSM, IDLE and PULSE.
REQ-023 SHALL, in pulse-mode IDLE with en=1 and start=1, load idx<=din, set valid<=1 and busy<=1, load counter<=PULSE_LEN-1, and move to PULSE.
REQ-024 SHALL, in pulse-mode IDLE with en=1 and start=0, set valid<=0.
REQ-025 SHALL, in PULSE with en=1, decrement the counter if it is nonzero; at counter==0 clear valid and busy and return to IDLE.
REQ-026 SHALL keep dout one-hot for exactly PULSE_LEN enabled cycles per pulse; cycles with en=0 extend the pulse.
REQ-027 SHALL ignore start while busy=1 (no retrigger).
REQ-028 SHALL, on a mode change with en=1, apply the new mode's rule on that edge; leaving mode 11 clears busy and the counter, and the FSM returns to IDLE.
REQ-029 SHALL size the counter at clog2(PULSE_LEN), minimum 1 bit.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, set dout=0, idx=0, valid=0, wrap=0, busy=0, counter=0 and FSM=IDLE.
REQ-031 SHALL give rst priority over en, mode and start, including mid-pulse and mid-scan.

Verification
REQ-032 SHALL cover: rst high 2 cycles -> dout=0000, idx=0, valid=0, busy=0, wrap=0.
REQ-033 SHALL cover: SEL_W=2, mode=00, en=1, din=2 -> next cycle dout=0100, idx=2, valid=1; then en=0, din=3 -> dout holds 0100.
REQ-034 SHALL cover: mode=01, en=1, din=2 from valid=0 -> dout 0100, 1000, 0001 (wrap=1 that cycle only), 0010.
REQ-035 SHALL cover: mode=10 seeded at din=0 -> 0001, then 1000 with wrap=1, then 0100 with wrap=0.
REQ-036 SHALL cover: PULSE_LEN=4, mode=11, din=1, start for 1 cycle -> dout=0010 and busy=1 for exactly 4 cycles, then 0000; start reasserted while busy is ignored; en=0 for 2 cycles mid-pulse -> pulse lasts 6 cycles.
REQ-037 SHALL cover: rst asserted in the 2nd pulse cycle -> next cycle dout=0000, busy=0, valid=0, FSM=IDLE.
